// File: rtl/alu_ex_stage.sv
// Execute stage between decoder and ALU: operand register (S1), result register (S2),
// forwarding from both in-flight slots, and valid/ready flow control on both sides.
module alu_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [4:0]   in_rs_a,
    input  logic [4:0]   in_rs_b,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [4:0]   in_rd,
    input  logic         in_we,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_res,
    input  logic         alu_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic         out_zero,
    output logic [4:0]   out_rd,
    output logic         out_we
);

    localparam logic [2:0] OP_SRL = 3'b101;

    logic         s1_valid;
    logic [2:0]   s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [4:0]   s1_rd;
    logic         s1_we;

    logic         s2_valid;
    logic [W-1:0] s2_res;
    logic         s2_zero;
    logic [4:0]   s2_rd;
    logic         s2_we;

    logic         s2_load;
    logic         accept;
    logic [W-1:0] fwd_a;
    logic [W-1:0] fwd_b;

    // Shift amount is confined to 0-31 so the ALU never sees an oversized shift.
    assign alu_a  = s1_a;
    assign alu_op = s1_op;
    assign alu_b  = (s1_op == OP_SRL) ? {{(W-5){1'b0}}, s1_b[4:0]} : s1_b;

    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = rst_n && (!s1_valid || s2_load);
    assign accept   = in_valid && in_ready;

    function automatic logic [W-1:0] forward(input logic [4:0] rs, input logic [W-1:0] rf_val);
        if (s1_valid && s1_we && (s1_rd != 5'd0) && (s1_rd == rs))
            forward = alu_res;
        else if (s2_valid && s2_we && (s2_rd != 5'd0) && (s2_rd == rs))
            forward = s2_res;
        else
            forward = rf_val;
    endfunction

    assign fwd_a = forward(in_rs_a, in_a);
    assign fwd_b = forward(in_rs_b, in_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rd    <= '0;
            s1_we    <= 1'b0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_zero  <= 1'b0;
            s2_rd    <= '0;
            s2_we    <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_res   <= alu_res;
                s2_zero  <= alu_zero;
                s2_rd    <= s1_rd;
                s2_we    <= s1_we;
            end else if (s2_valid && out_ready) begin
                s2_valid <= 1'b0;
            end

            // Operands are fixed at capture; a stalled S1 keeps what it forwarded.
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= in_op;
                s1_a     <= fwd_a;
                s1_b     <= fwd_b;
                s1_rd    <= in_rd;
                s1_we    <= in_we;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_res   = s2_res;
    assign out_zero  = s2_zero;
    assign out_rd    = s2_rd;
    assign out_we    = s2_we;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage; the bench supplies its own ALU model, driven
// from the stage's operand outputs, to produce the expected results.
module tb_alu_ex_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [4:0]   in_rs_a, in_rs_b, in_rd;
    logic [W-1:0] in_a, in_b;
    logic         in_we;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic [2:0]   alu_op;
    logic         alu_zero;
    logic         out_valid, out_ready;
    logic [W-1:0] out_res;
    logic         out_zero, out_we;
    logic [4:0]   out_rd;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_ex_stage #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_a(in_a), .in_b(in_b),
        .in_rd(in_rd), .in_we(in_we),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_rd(out_rd), .out_we(out_we)
    );

    // Reference ALU driven by the stage's operand outputs.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = alu_a & alu_b;
            3'b001: alu_res = alu_a | alu_b;
            3'b010: alu_res = alu_a + alu_b;
            3'b011: alu_res = alu_a ^ alu_b;
            3'b100: alu_res = ~(alu_a | alu_b);
            3'b101: alu_res = alu_a >> alu_b;
            3'b110: alu_res = alu_a - alu_b;
            3'b111: alu_res = {{(W-1){1'b0}}, (alu_a < alu_b)};
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == '0);
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs_a, input logic [4:0] rs_b,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] rd, input logic we);
        in_valid = 1'b1;
        in_op    = op;
        in_rs_a  = rs_a;
        in_rs_b  = rs_b;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        in_we    = we;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0; in_op = '0; in_rs_a = '0; in_rs_b = '0;
        in_a = '0; in_b = '0; in_rd = '0; in_we = 1'b0;

        // Reset state
        step(); step();
        checkOutput("rst_out_valid", W'(out_valid), 0);
        checkOutput("rst_out_res", out_res, 0);
        checkOutput("rst_in_ready", W'(in_ready), 0);
        checkOutput("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", W'(in_ready), 1);

        // Single add, latency
        applyStimulus(3'b010, 5'd10, 5'd11, 5, 7, 5'd3, 1'b1);
        step();
        checkOutput("add_alu_a", alu_a, 5);
        checkOutput("add_alu_b", alu_b, 7);
        checkOutput("add_early_valid", W'(out_valid), 0);
        idle();
        step();
        checkOutput("add_valid", W'(out_valid), 1);
        checkOutput("add_res", out_res, 12);
        checkOutput("add_zero", W'(out_zero), 0);
        checkOutput("add_rd", W'(out_rd), 3);
        checkOutput("add_we", W'(out_we), 1);
        step();
        checkOutput("add_drained", W'(out_valid), 0);

        // Back-to-back dependency, S1 forward
        applyStimulus(3'b010, 5'd20, 5'd21, 2, 3, 5'd1, 1'b1);
        step();
        applyStimulus(3'b110, 5'd1, 5'd22, 0, 5, 5'd2, 1'b1);
        step();
        checkOutput("s1fwd_first_res", out_res, 5);
        idle();
        step();
        checkOutput("s1fwd_sub_res", out_res, 0);
        checkOutput("s1fwd_sub_zero", W'(out_zero), 1);
        checkOutput("s1fwd_sub_rd", W'(out_rd), 2);
        step();

        // Dependency with a gap, S2 forward while S2 is consumed
        applyStimulus(3'b010, 5'd20, 5'd21, 2, 3, 5'd1, 1'b1);
        step();
        idle();
        step();
        checkOutput("s2fwd_first_res", out_res, 5);
        applyStimulus(3'b110, 5'd1, 5'd22, 0, 5, 5'd2, 1'b1);
        step();
        idle();
        step();
        checkOutput("s2fwd_sub_valid", W'(out_valid), 1);
        checkOutput("s2fwd_sub_res", out_res, 0);
        checkOutput("s2fwd_sub_zero", W'(out_zero), 1);
        step();

        // Register 0 is never forwarded
        applyStimulus(3'b010, 5'd20, 5'd21, 4, 4, 5'd0, 1'b1);
        step();
        applyStimulus(3'b001, 5'd0, 5'd23, 9, 0, 5'd5, 1'b1);
        step();
        checkOutput("r0_first_res", out_res, 8);
        idle();
        step();
        checkOutput("r0_no_fwd_res", out_res, 9);
        step();

        // Shift amount masking
        applyStimulus(3'b101, 5'd28, 5'd29, 32'h8000_0000, 32'h0000_0021, 5'd6, 1'b1);
        step();
        checkOutput("srl_alu_b", alu_b, 1);
        idle();
        step();
        checkOutput("srl_res", out_res, 32'h4000_0000);
        step();

        // Backpressure: two held, third stalled, release in order
        out_ready = 1'b0;
        applyStimulus(3'b010, 5'd24, 5'd25, 1, 1, 5'd4, 1'b1);
        step();
        checkOutput("bp_ready_after1", W'(in_ready), 1);
        applyStimulus(3'b010, 5'd24, 5'd25, 3, 3, 5'd5, 1'b1);
        step();
        checkOutput("bp_ready_full", W'(in_ready), 0);
        checkOutput("bp_res_first", out_res, 2);
        applyStimulus(3'b010, 5'd24, 5'd25, 10, 10, 5'd6, 1'b1);
        step();
        checkOutput("bp_ready_still0", W'(in_ready), 0);
        checkOutput("bp_res_hold", out_res, 2);
        checkOutput("bp_rd_hold", W'(out_rd), 4);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_comb", W'(in_ready), 1);
        step();
        checkOutput("bp_res_second", out_res, 6);
        checkOutput("bp_rd_second", W'(out_rd), 5);
        idle();
        step();
        checkOutput("bp_res_third", out_res, 20);
        checkOutput("bp_rd_third", W'(out_rd), 6);
        step();
        checkOutput("bp_drained", W'(out_valid), 0);

        // Reset with both slots full
        out_ready = 1'b0;
        applyStimulus(3'b010, 5'd24, 5'd25, 7, 1, 5'd7, 1'b1);
        step();
        applyStimulus(3'b010, 5'd24, 5'd25, 2, 2, 5'd8, 1'b1);
        step();
        checkOutput("rst2_full_valid", W'(out_valid), 1);
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_in_ready", W'(in_ready), 0);
        step();
        checkOutput("rst2_out_valid", W'(out_valid), 0);
        checkOutput("rst2_out_res", out_res, 0);
        checkOutput("rst2_alu_a", alu_a, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(3'b010, 5'd26, 5'd27, 100, 23, 5'd9, 1'b1);
        step();
        checkOutput("rst2_no_stale", W'(out_valid), 0);
        idle();
        step();
        checkOutput("rst2_new_res", out_res, 123);
        checkOutput("rst2_new_rd", W'(out_rd), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
